sdram_port_responder: RTL

Block-RAM-backed responder for the `sdram_port_if` client protocol. It serves the addr/data/wr/rd/byte_en requests issued by SDRAM port clients and returns q/ready. It is used in builds and benches without physical SDRAM. Programmable read/write latency and periodic refresh stalls reproduce the controller-side timing that clients must tolerate.

---
 rtl/sdram_port_responder_if.sv | 16 +
 rtl/sdram_port_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port_responder_if.sv
// Client/server bundle for an SDRAM port: request fields in, q/ready back.
interface sdram_port_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic                    wr;
    logic                    rd;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [DATA_WIDTH-1:0]   q;
    logic                    ready;

    modport server (input addr, data, wr, rd, byte_en, output q, ready);
    modport client (output addr, data, wr, rd, byte_en, input q, ready);
endinterface

// File: rtl/sdram_port_responder.sv
// Block-RAM model of an SDRAM port: byte-lane writes, programmable read/write
// latency and periodic refresh stalls as a controller would impose them.
module sdram_port_responder #(
    parameter int ADDR_WIDTH       = 21,
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_ADDR_BITS    = 14,
    parameter int READ_LATENCY     = 2,
    parameter int WRITE_LATENCY    = 1,
    parameter int REFRESH_INTERVAL = 0,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic         clk_logic,
    input  logic         system_reset_n,
    sdram_port_if.server mem_if
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int RC_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [3:0] RD_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD  = 4'(WRITE_LATENCY - 1);
    localparam logic [3:0] REF_LOAD = 4'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, REFRESH} state_t;

    state_t                   state_q;
    logic [3:0]               lat_cnt_q;
    logic                     ready_q;
    logic                     q_sel_q;
    logic                     live_q;
    logic                     refresh_pending_q;
    logic [MEM_ADDR_BITS-1:0] idx_q;
    logic [DATA_WIDTH-1:0]    q_hold_q;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     refresh_tick;
    logic                     accept_slot;
    logic                     wr_commit;
    logic [MEM_ADDR_BITS-1:0] req_idx;

    assign req_idx = mem_if.addr[MEM_ADDR_BITS-1:0];

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^mem_if.addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

    // The last REFRESH cycle doubles as an IDLE slot so a held request is
    // taken on the very edge the stall ends.
    assign accept_slot = live_q && ((state_q == IDLE) ||
                         (state_q == REFRESH && lat_cnt_q == 4'd0));
    assign wr_commit   = accept_slot && !refresh_pending_q && mem_if.wr;

    generate
        if (REFRESH_INTERVAL > 0) begin : g_refresh
            logic [RC_W-1:0] ref_cnt_q;
            assign refresh_tick = (ref_cnt_q == RC_W'(REFRESH_INTERVAL - 1));
            always_ff @(posedge clk_logic or negedge system_reset_n) begin
                if (!system_reset_n) begin
                    ref_cnt_q <= '0;
                end else if (refresh_tick) begin
                    ref_cnt_q <= '0;
                end else begin
                    ref_cnt_q <= ref_cnt_q + RC_W'(1);
                end
            end
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q           <= IDLE;
            lat_cnt_q         <= 4'd0;
            ready_q           <= 1'b0;
            q_sel_q           <= 1'b0;
            live_q            <= 1'b0;
            refresh_pending_q <= 1'b0;
            idx_q             <= '0;
            q_hold_q          <= '0;
        end else begin
            // live_q keeps the memory from taking a write on an edge that
            // occurs while reset is still low.
            live_q  <= 1'b1;
            ready_q <= 1'b0;
            q_sel_q <= 1'b0;
            if (q_sel_q) begin
                q_hold_q <= rd_data;
            end

            case (state_q)
                READ_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        ready_q <= 1'b1;
                        q_sel_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                WRITE_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                REFRESH: begin
                    if (lat_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase

            if (accept_slot) begin
                if (refresh_pending_q) begin
                    state_q   <= REFRESH;
                    lat_cnt_q <= REF_LOAD;
                end else if (mem_if.wr) begin
                    state_q   <= WRITE_WAIT;
                    lat_cnt_q <= WR_LOAD;
                    idx_q     <= req_idx;
                end else if (mem_if.rd) begin
                    state_q   <= READ_WAIT;
                    lat_cnt_q <= RD_LOAD;
                    idx_q     <= req_idx;
                end
            end

            if (refresh_tick) begin
                refresh_pending_q <= 1'b1;
            end else if (accept_slot && refresh_pending_q) begin
                refresh_pending_q <= 1'b0;
            end
        end
    end

    // One byte-wide RAM per lane; the read register runs every cycle and is
    // only exposed on q in the cycle after a read completes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge clk_logic) begin
                if (wr_commit && mem_if.byte_en[gi]) begin
                    lane_mem[req_idx] <= mem_if.data[gi*8 +: 8];
                end
                lane_rd_q <= lane_mem[idx_q];
            end
            assign rd_data[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    assign mem_if.ready = ready_q;
    assign mem_if.q     = q_sel_q ? rd_data : q_hold_q;
endmodule
